// File: rtl/extend_pkg.sv
// Shared widths, mode encodings and mode type for the immediate extension unit.
package extend_pkg;

  localparam int IMM_W = 12;
  localparam int XLEN  = 32;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN      = 2'b00;
  localparam ext_mode_t EXT_ZERO      = 2'b01;
  localparam ext_mode_t EXT_SIGN_SH1  = 2'b10;
  localparam ext_mode_t EXT_SIGN_SH12 = 2'b11;

endpackage

// File: rtl/extend_core.sv
// Combinational 12-to-32-bit immediate extension: sign, zero and pre-shifted sign forms.
module extend_core
  import extend_pkg::*;
(
  input  logic [IMM_W-1:0] extender,
  input  ext_mode_t        mode,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] sext;

  assign sext = {{(XLEN-IMM_W){extender[IMM_W-1]}}, extender};

  // Shifted forms drop the bits pushed past bit 31; no overflow is reported.
  always_comb begin
    result = sext;
    case (mode)
      EXT_SIGN:      result = sext;
      EXT_ZERO:      result = {{(XLEN-IMM_W){1'b0}}, extender};
      EXT_SIGN_SH1:  result = {sext[XLEN-2:0], 1'b0};
      EXT_SIGN_SH12: result = {sext[XLEN-13:0], 12'b0};
      default:       result = sext;
    endcase
  end

endmodule

// File: rtl/extend_unit_12to32.sv
// Registered immediate extension unit: one-cycle latency, output held when no valid input.
module extend_unit_12to32
  import extend_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IMM_W-1:0] extender,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [XLEN-1:0]  extendido,
  output logic             out_valid
);

  logic [XLEN-1:0] core_result;
  logic [XLEN-1:0] extendido_d, extendido_q;
  logic            out_valid_d, out_valid_q;

  extend_core u_core (
    .extender (extender),
    .mode     (ext_mode_t'(mode)),
    .result   (core_result)
  );

  // Only select the core result when valid, so undriven inputs never reach the register.
  always_comb begin
    extendido_d = extendido_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      extendido_d = core_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      extendido_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      extendido_q <= extendido_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign extendido = extendido_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_extend_unit_12to32.sv
// Self-checking bench for extend_unit_12to32: directed cases plus random traffic against an arithmetic model.
module tb_extend_unit_12to32;

  logic        clk;
  logic        rst_n;
  logic [11:0] extender;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] extendido;
  logic        out_valid;

  int checks;
  int failures;

  logic [31:0] exp_ext;
  logic        exp_v;

  extend_unit_12to32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .extender  (extender),
    .mode      (mode),
    .in_valid  (in_valid),
    .extendido (extendido),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the immediate as a signed integer and scale it.
  function automatic logic [31:0] model(input logic [11:0] imm, input logic [1:0] m);
    int v;
    int u;
    u = int'(imm);
    v = (u >= 2048) ? (u - 4096) : u;
    case (m)
      2'd0:    return 32'(v);
      2'd1:    return 32'(u);
      2'd2:    return 32'(v * 2);
      default: return 32'(v * 4096);
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive at negedge, then check one edge later.
  task automatic step(input string tag, input logic [11:0] imm, input logic [1:0] m,
                      input logic v);
    @(negedge clk);
    extender = imm;
    mode     = m;
    in_valid = v;
    if (v) exp_ext = model(imm, m);
    exp_v = v;
    @(posedge clk);
    #1;
    check32(tag, extendido, exp_ext);
    check1({tag, "_valid"}, out_valid, exp_v);
  endtask

  task automatic step_exact(input string tag, input logic [11:0] imm, input logic [1:0] m,
                            input logic [31:0] want);
    step(tag, imm, m, 1'b1);
    check32({tag, "_const"}, extendido, want);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ext  = 32'h0;
    exp_v    = 1'b0;
    rst_n    = 1'b0;
    extender = 12'hAAA;
    mode     = 2'b00;
    in_valid = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check32("reset_ext", extendido, 32'h0);
    check1("reset_valid", out_valid, 1'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check1("post_reset_idle", out_valid, 1'b0);

    step_exact("sign_000", 12'h000, 2'b00, 32'h00000000);
    step_exact("sign_aaa", 12'hAAA, 2'b00, 32'hFFFFFAAA);
    step_exact("sign_555", 12'h555, 2'b00, 32'h00000555);
    step_exact("zero_aaa", 12'hAAA, 2'b01, 32'h00000AAA);
    step_exact("zero_fff", 12'hFFF, 2'b01, 32'h00000FFF);
    step_exact("sh1_aaa",  12'hAAA, 2'b10, 32'hFFFFF554);
    step_exact("sh1_7ff",  12'h7FF, 2'b10, 32'h00000FFE);
    step_exact("sh12_800", 12'h800, 2'b11, 32'hFF800000);
    step_exact("sh12_001", 12'h001, 2'b11, 32'h00001000);

    step_exact("hold_load", 12'h555, 2'b00, 32'h00000555);
    @(negedge clk);
    in_valid = 1'b0;
    extender = 12'bx;
    mode     = 2'bx;
    @(posedge clk);
    #1;
    check32("hold_ext", extendido, 32'h00000555);
    check1("hold_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check32("hold_ext2", extendido, 32'h00000555);

    for (int i = 0; i < 300; i++) begin
      step("rand", 12'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    step_exact("pre_midrst", 12'h9C3, 2'b10, 32'hFFFFF386);
    @(negedge clk);
    extender = 12'h123;
    mode     = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check32("midrst_ext", extendido, 32'h0);
    check1("midrst_valid", out_valid, 1'b0);
    exp_ext = 32'h0;
    exp_v   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step_exact("after_rst", 12'hFFF, 2'b11, 32'hFFFFF000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
